// File: rtl/run_detect_pkg.sv
// Shared types for the multi-channel consecutive-ones run detector.
// Run states are derived from the per-channel run count; detection mode selects overlap behaviour.
package run_detect_pkg;

   typedef enum logic [1:0] {
      RUN_IDLE  = 2'd0,
      RUN_COUNT = 2'd1,
      RUN_HIT   = 2'd2
   } run_state_t;

   typedef enum logic {
      MODE_OVERLAP    = 1'b0,
      MODE_NONOVERLAP = 1'b1
   } detect_mode_t;

   // Encoding used for a run count that lies beyond RUN_LEN.
   localparam logic [1:0] RUN_STATE_INVALID = 2'd3;

endpackage

// File: rtl/run_detect_chan.sv
// One detector channel: run counter, registered detection flag and saturating hit counter.
// The run state is decoded from the count each cycle rather than stored.
module run_detect_chan
   import run_detect_pkg::*;
#(
   parameter int unsigned RUN_LEN = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             clr,
   input  logic             in,
   output logic             out,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam int unsigned      R_W       = $clog2(RUN_LEN + 1);
   localparam logic [R_W-1:0]   RUN_LEN_V = R_W'(RUN_LEN);
   localparam logic [R_W-1:0]   ONE_V     = R_W'(1);
   localparam logic [R_W-1:0]   ZERO_V    = {R_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX_V = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE_V = CNT_W'(1);

   logic [R_W-1:0]   r_r;
   logic [R_W-1:0]   rn_s;
   logic             out_r;
   logic             out_nx_s;
   logic             hit_s;
   logic [CNT_W-1:0] cnt_r;
   run_state_t       state_s;
   detect_mode_t     mode_s;

   assign mode_s = detect_mode_t'(mode);

   // Decode the run count into its state; counts above RUN_LEN map to the invalid encoding.
   always_comb begin
      state_s = RUN_IDLE;
      if (r_r == ZERO_V) begin
         state_s = RUN_IDLE;
      end else if (r_r < RUN_LEN_V) begin
         state_s = RUN_COUNT;
      end else if (r_r == RUN_LEN_V) begin
         state_s = RUN_HIT;
      end else begin
         state_s = run_state_t'(RUN_STATE_INVALID);
      end
   end

   // Next run count, next detection flag and hit event for the current input bit.
   always_comb begin
      rn_s     = ZERO_V;
      out_nx_s = 1'b0;
      hit_s    = 1'b0;
      if (in) begin
         case (state_s)
            RUN_IDLE, RUN_COUNT: rn_s = r_r + ONE_V;
            RUN_HIT: begin
               if (mode_s == MODE_NONOVERLAP) begin
                  rn_s = ONE_V;
               end else begin
                  rn_s = RUN_LEN_V;
               end
            end
            default: rn_s = ZERO_V;
         endcase
         out_nx_s = (rn_s == RUN_LEN_V);
         // In overlap mode a run stuck in HIT is counted only once, at entry.
         hit_s    = out_nx_s && ((state_s != RUN_HIT) || (mode_s == MODE_NONOVERLAP));
      end else begin
         rn_s = ZERO_V;
      end
   end

   // Run count, registered flag and saturating hit counter; clr outranks a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r   <= ZERO_V;
         out_r <= 1'b0;
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (en) begin
            r_r   <= rn_s;
            out_r <= out_nx_s;
         end else begin
            out_r <= 1'b0;
         end
         if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (en && hit_s && (cnt_r != CNT_MAX_V)) begin
            cnt_r <= cnt_r + CNT_ONE_V;
         end
      end
   end

   assign out     = out_r;
   assign hit_cnt = cnt_r;

endmodule

// File: rtl/run_detect_fsm.sv
// Multi-channel run detector: CHANNELS independent copies of run_detect_chan.
// Channel c owns in[c], out[c] and hit_cnt[c*CNT_W +: CNT_W].
module run_detect_fsm
   import run_detect_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned RUN_LEN  = 2,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      mode,
   input  logic                      clr,
   input  logic [CHANNELS-1:0]       in,
   output logic [CHANNELS-1:0]       out,
   output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      run_detect_chan #(
         .RUN_LEN (RUN_LEN),
         .CNT_W   (CNT_W)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .mode    (mode),
         .clr     (clr),
         .in      (in[c]),
         .out     (out[c]),
         .hit_cnt (hit_cnt[c*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_run_detect_fsm.sv
// Directed and model-based bench for run_detect_fsm.
// dut_a: 4 channels, RUN_LEN=3, CNT_W=8.  dut_b: 1 channel, RUN_LEN=1, CNT_W=2.
module tb_run_detect_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_a = 1'b0, mode_a = 1'b0, clr_a = 1'b0;
   logic [3:0]  in_a = 4'd0;
   logic [3:0]  out_a;
   logic [31:0] hit_a;
   logic        en_b = 1'b0, mode_b = 1'b0, clr_b = 1'b0;
   logic [0:0]  in_b = 1'b0;
   logic [0:0]  out_b;
   logic [1:0]  hit_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   run_detect_fsm #(.CHANNELS(4), .RUN_LEN(3), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .clr(clr_a),
      .in(in_a), .out(out_a), .hit_cnt(hit_a)
   );

   run_detect_fsm #(.CHANNELS(1), .RUN_LEN(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .clr(clr_b),
      .in(in_b), .out(out_b), .hit_cnt(hit_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (out_a !== 4'd0 || hit_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_a: out=%b hit=%h want 0", out_a, hit_a);
      end
      checks++;
      if (out_b !== 1'b0 || hit_b !== 2'd0) begin
         errors++;
         $display("FAIL reset_b: out=%b hit=%h want 0", out_b, hit_b);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_overlap;
      logic pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      mode_a = 1'b0; en_a = 1'b1; in_a = 4'd0; clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_a[0] = pat[i];
         tick();
         checks++;
         if (out_a[0] !== exp[i]) begin
            errors++;
            $display("FAIL overlap_out step %0d: got %b want %b", i, out_a[0], exp[i]);
         end
      end
      checks++;
      if (hit_a[7:0] !== 8'd1) begin
         errors++;
         $display("FAIL overlap_cnt: got %0d want 1", hit_a[7:0]);
      end
   endtask

   task automatic test_nonoverlap;
      logic exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      mode_a = 1'b1; in_a = 4'd0; clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_a[0] = 1'b1;
         tick();
         checks++;
         if (out_a[0] !== exp[i]) begin
            errors++;
            $display("FAIL nonoverlap_out step %0d: got %b want %b", i, out_a[0], exp[i]);
         end
      end
      in_a = 4'd0;
      tick();
      checks++;
      if (hit_a[7:0] !== 8'd2) begin
         errors++;
         $display("FAIL nonoverlap_cnt: got %0d want 2", hit_a[7:0]);
      end
   endtask

   task automatic test_enable;
      mode_a = 1'b0; in_a = 4'd0; clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      in_a[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (out_a[1] !== 1'b0) begin
            errors++;
            $display("FAIL enable_pre step %0d: got %b want 0", i, out_a[1]);
         end
      end
      en_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_a !== 4'd0) begin
            errors++;
            $display("FAIL enable_off step %0d: got %b want 0000", i, out_a);
         end
      end
      en_a = 1'b1;
      tick();
      checks++;
      if (out_a[1] !== 1'b1) begin
         errors++;
         $display("FAIL enable_hit: got %b want 1", out_a[1]);
      end
      in_a = 4'd0;
      tick();
      checks++;
      if (out_a[1] !== 1'b0 || hit_a[15:8] !== 8'd1) begin
         errors++;
         $display("FAIL enable_post: out=%b cnt=%0d want 0 and 1", out_a[1], hit_a[15:8]);
      end
   endtask

   task automatic test_reset_midrun;
      logic exp [3] = '{1'b0, 1'b0, 1'b1};
      in_a[0] = 1'b1;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_a !== 4'd0 || hit_a !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset: out=%b hit=%h want 0", out_a, hit_a);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_a[0] !== exp[i]) begin
            errors++;
            $display("FAIL midrun_after step %0d: got %b want %b", i, out_a[0], exp[i]);
         end
      end
      in_a = 4'd0;
      tick();
   endtask

   task automatic test_sat_clr;
      logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      en_b = 1'b1; mode_b = 1'b1; in_b = 1'b0; clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      in_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (hit_b !== exp[i] || out_b !== 1'b1) begin
            errors++;
            $display("FAIL sat step %0d: cnt=%0d out=%b want %0d and 1", i, hit_b, out_b, exp[i]);
         end
      end
      clr_b = 1'b1;
      tick();
      checks++;
      if (hit_b !== 2'd0 || out_b !== 1'b1) begin
         errors++;
         $display("FAIL clr_priority: cnt=%0d out=%b want 0 and 1", hit_b, out_b);
      end
      clr_b = 1'b0;
   endtask

   task automatic test_mode_switch;
      mode_b = 1'b0; in_b = 1'b0;
      tick();
      in_b = 1'b1;
      tick();
      checks++;
      if (out_b !== 1'b1 || hit_b !== 2'd1) begin
         errors++;
         $display("FAIL switch_entry: out=%b cnt=%0d want 1 and 1", out_b, hit_b);
      end
      tick();
      checks++;
      if (out_b !== 1'b1 || hit_b !== 2'd1) begin
         errors++;
         $display("FAIL switch_hold: out=%b cnt=%0d want 1 and 1", out_b, hit_b);
      end
      mode_b = 1'b1;
      tick();
      checks++;
      if (out_b !== 1'b1 || hit_b !== 2'd2) begin
         errors++;
         $display("FAIL switch_nonoverlap: out=%b cnt=%0d want 1 and 2", out_b, hit_b);
      end
   endtask

   task automatic test_delay;
      logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      mode_b = 1'b0; in_b = 1'b0; clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_b = pat[i];
         tick();
         checks++;
         if (out_b !== pat[i]) begin
            errors++;
            $display("FAIL delay step %0d: got %b want %b", i, out_b, pat[i]);
         end
      end
      checks++;
      if (hit_b !== 2'd2) begin
         errors++;
         $display("FAIL delay_cnt: got %0d want 2", hit_b);
      end
   endtask

   task automatic test_random;
      int          mr [4];
      int          mc [4];
      int          nr;
      logic        hit;
      logic [3:0]  eo;
      logic [31:0] eh;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         mr[c] = 0;
         mc[c] = 0;
      end
      mode_a = 1'b0; clr_a = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         en_a = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) mode_a = ~mode_a;
         clr_a = ($urandom_range(0, 99) == 0);
         in_a = 4'($urandom_range(0, 15));
         in_a[2] = 1'b0;
         for (int c = 0; c < 4; c++) begin
            hit = 1'b0;
            eo[c] = 1'b0;
            if (en_a) begin
               if (in_a[c]) begin
                  nr = (mr[c] < 3) ? mr[c] + 1 : (mode_a ? 1 : 3);
                  eo[c] = (nr == 3);
                  hit = (nr == 3) && ((mr[c] < 3) || mode_a);
                  mr[c] = nr;
               end else begin
                  mr[c] = 0;
               end
            end
            if (clr_a) mc[c] = 0;
            else if (hit && mc[c] < 255) mc[c] = mc[c] + 1;
            eh[c*8 +: 8] = 8'(mc[c]);
         end
         tick();
         checks++;
         if (out_a !== eo || hit_a !== eh) begin
            errors++;
            $display("FAIL random cycle %0d: out=%b hit=%h want %b %h", n, out_a, hit_a, eo, eh);
         end
         checks++;
         if (out_a[2] !== 1'b0 || hit_a[23:16] !== 8'd0) begin
            errors++;
            $display("FAIL quiet_chan2 cycle %0d: out=%b cnt=%0d want 0", n, out_a[2], hit_a[23:16]);
         end
      end
      en_a = 1'b1; clr_a = 1'b0; in_a = 4'd0;
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_enable();
      test_reset_midrun();
      test_sat_clr();
      test_mode_switch();
      test_delay();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_detect_fsm.md
RUN_DETECT_FSM -- requirements
Module: run_detect_fsm

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter RUN_LEN, default 2: consecutive-ones run length that constitutes a detection, range 1..255.
REQ-003 Parameter CNT_W, default 8: width of each per-channel hit counter, range 1..32.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assertion, active-low.
REQ-006 en  input  1: sample enable; channel inputs are evaluated only in cycles with en=1.
REQ-007 mode  input  1: 0 = overlapping detection, 1 = non-overlapping detection.
REQ-008 clr  input  1: synchronous clear of all hit counters.
REQ-009 in  input  CHANNELS: one serial data bit per channel.
REQ-010 out  output  CHANNELS: registered per-channel detection flag.
REQ-011 hit_cnt  output  CHANNELS*CNT_W: per-channel hit counters, channel c in bits [c*CNT_W +: CNT_W].

Function
REQ-012 Each channel SHALL hold a run count r in range 0..RUN_LEN, width $clog2(RUN_LEN+1).
REQ-013 Per-channel states SHALL be IDLE (r=0), COUNT (0<r<RUN_LEN), and HIT (r=RUN_LEN); the state is derived from r and is not stored separately.
REQ-014 With en=1 and in[c]=0: r <= 0, out[c] <= 0.
REQ-015 With en=1 and in[c]=1: the next count rn SHALL be r+1 when r<RUN_LEN; when r=RUN_LEN, rn SHALL be RUN_LEN if mode=0 and 1 if mode=1; r <= rn.
REQ-016 With en=1: out[c] <= 1 exactly when in[c]=1 and rn=RUN_LEN; otherwise out[c] <= 0. Latency is one cycle from the sampled bit to out.
REQ-017 A hit event SHALL occur when in[c]=1, rn=RUN_LEN, and either r<RUN_LEN or mode=1; in mode 0, a run is counted once, at entry to HIT.
REQ-018 On a hit event, hit_cnt[c] SHALL increment by 1 and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-019 With en=0: r and hit_cnt SHALL hold and out SHALL be driven to 0 on the next edge.
REQ-020 clr=1 SHALL set all hit_cnt to 0 on the next edge; clr takes priority over a simultaneous hit event and does not affect r or out.
REQ-021 A mode change SHALL take effect on the next sampled cycle with no flush; a HIT-state channel with in=1 and mode newly 1 SHALL go to r=1 and record a hit.
REQ-022 RUN_LEN=1 SHALL give out[c] equal to in[c] delayed by one cycle; in mode 1, every 1 is a hit.
REQ-023 RUN_LEN=2 with mode=0 SHALL reproduce the legacy single-channel two-ones Mealy detector behaviour on each channel.
REQ-024 Channels SHALL be fully independent, with no cross-channel interaction.

Reset
REQ-025 While rst_n=0, every r, out bit, and hit_cnt SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-run SHALL discard partial runs; after release, a full RUN_LEN ones are needed for the next detection.
REQ-027 An out-of-range r value SHALL return to 0 on the next edge (default branch).

Structure
REQ-028 Package run_detect_pkg SHALL hold the run_state_t enum (RUN_IDLE, RUN_COUNT, RUN_HIT) and the detect_mode_t enum (MODE_OVERLAP=0, MODE_NONOVERLAP=1).
REQ-029 Per-channel logic SHALL be sub-module run_detect_chan, holding r, out, and hit_cnt in a single always_ff block, with parameters RUN_LEN and CNT_W.
REQ-030 The top level SHALL instantiate CHANNELS copies of run_detect_chan in a generate loop; the top level contains no other logic.

Verification
REQ-031 RUN_LEN=3, mode=0, en=1: in[0] pattern 1,1,1,1,1,0 -> out[0] = 0,0,1,1,1,0 one cycle later; hit_cnt[0]=1.
REQ-032 RUN_LEN=3, mode=1: in[0] with six 1s -> out[0] high on the 3rd and 6th samples only; hit_cnt[0]=2.
REQ-033 RUN_LEN=3: in[1] = 1,1, then en=0 for 4 cycles, then 1 -> out[1] pulses on the third sampled 1; out[1]=0 during en=0.
REQ-034 CNT_W=2, mode=1, RUN_LEN=1: 5 consecutive 1s -> hit_cnt saturates at 3; clr asserted in the same cycle as a hit -> hit_cnt=0.
REQ-035 RUN_LEN=3: rst_n pulsed low after two 1s -> all outputs are 0 immediately; two further 1s give no detection, a third gives out=1.
REQ-036 CHANNELS=4, random independent streams for 10k cycles -> out and hit_cnt match a per-channel reference model; channel 2 held at 0 -> out[2]=0 and hit_cnt[2]=0 throughout.
